// File: rtl/burst_data_memory.sv
// Backing data memory below the L2 cache: single-word writes and line-aligned
// fixed-length burst reads with a programmable first-beat latency.
module burst_data_memory #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int BURST_LEN   = 8,
    parameter int RD_LAT      = 2,
    parameter int INIT_ON_RST = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         wr_done,
    output logic                         rd_valid,
    output logic                         rd_last,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(BURST_LEN):0]   beat_cnt,
    output logic                         busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BW    = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

    state_t              r_state, w_stateNext;
    logic [3:0]          r_latCnt, w_latNext;
    logic [BW-1:0]       r_beatCnt, w_beatNext;
    logic [ADDR_W-1:0]   r_base, w_baseNext;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rdHold;
    logic                r_wrDone;
    logic                w_accept;
    logic                w_wrAccept;
    logic                w_rdAccept;
    logic                w_lastBeat;
    logic [ADDR_W-1:0]   w_rdAddr;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_wrAccept = w_accept && req_write;
    assign w_rdAccept = w_accept && !req_write;
    // Base is line-aligned, so the add wraps naturally modulo depth.
    assign w_rdAddr   = r_base + ADDR_W'(r_beatCnt);
    assign w_lastBeat = (r_beatCnt == BW'(BURST_LEN - 1));

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_WAIT) || (r_state == S_BURST);
    assign rd_valid  = (r_state == S_BURST);
    assign rd_last   = (r_state == S_BURST) && w_lastBeat;
    assign rd_data   = (r_state == S_BURST) ? r_mem[w_rdAddr] : r_rdHold;
    assign beat_cnt  = r_beatCnt;
    assign wr_done   = r_wrDone;

    always_comb begin
        w_stateNext = r_state;
        w_latNext   = r_latCnt;
        w_beatNext  = r_beatCnt;
        w_baseNext  = r_base;
        unique case (r_state)
            S_IDLE: begin
                w_beatNext = '0;
                if (w_rdAccept) begin
                    w_baseNext = req_addr & ~ADDR_W'(BURST_LEN - 1);
                    if (RD_LAT > 0) begin
                        w_stateNext = S_WAIT;
                        w_latNext   = 4'(RD_LAT - 1);
                    end else begin
                        w_stateNext = S_BURST;
                    end
                end
            end
            S_WAIT: begin
                if (r_latCnt == '0) begin
                    w_stateNext = S_BURST;
                end else begin
                    w_latNext = r_latCnt - 4'd1;
                end
            end
            S_BURST: begin
                w_beatNext = r_beatCnt + BW'(1);
                if (w_lastBeat) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
                w_beatNext  = '0;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_latCnt  <= '0;
            r_beatCnt <= '0;
            r_base    <= '0;
            r_wrDone  <= 1'b0;
            r_rdHold  <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_latCnt  <= w_latNext;
            r_beatCnt <= w_beatNext;
            r_base    <= w_baseNext;
            r_wrDone  <= w_wrAccept;
            if (r_state == S_BURST) begin
                r_rdHold <= r_mem[w_rdAddr];
            end
        end
    end

    // Reset takes priority, so a write offered alongside rst is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (INIT_ON_RST != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= DATA_W'(i);
                end
            end
        end else if (w_wrAccept) begin
            r_mem[req_addr] <= req_wdata;
        end
    end
endmodule

// File: tb/tb_burst_data_memory.sv
// Self-checking bench for burst_data_memory: a cycle-timeline reference model
// of the memory contents checked against a default and a short-burst instance.
module tb_burst_data_memory;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        req_valid, req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready, wr_done, rd_valid, rd_last, busy;
    logic [31:0] rd_data;
    logic [3:0]  beat_cnt;

    logic        b_req_valid, b_req_write;
    logic [4:0]  b_req_addr;
    logic [31:0] b_req_wdata;
    logic        b_req_ready, b_wr_done, b_rd_valid, b_rd_last, b_busy;
    logic [31:0] b_rd_data;
    logic [2:0]  b_beat_cnt;

    int nChecks = 0;
    int nPassed = 0;
    int nFailed = 0;

    logic [31:0] refMem [32];
    logic [31:0] refB   [32];

    burst_data_memory #(
        .DATA_W(32), .ADDR_W(5), .BURST_LEN(8), .RD_LAT(2), .INIT_ON_RST(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .wr_done(wr_done),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data),
        .beat_cnt(beat_cnt), .busy(busy)
    );

    burst_data_memory #(
        .DATA_W(32), .ADDR_W(5), .BURST_LEN(4), .RD_LAT(0), .INIT_ON_RST(1)
    ) dutShort (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .wr_done(b_wr_done),
        .rd_valid(b_rd_valid), .rd_last(b_rd_last), .rd_data(b_rd_data),
        .beat_cnt(b_beat_cnt), .busy(b_busy)
    );

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPassed++;
        else begin
            nFailed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic applyShort(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
        b_req_valid = v;
        b_req_write = w;
        b_req_addr  = a;
        b_req_wdata = d;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 32; i++) begin
            refMem[i] = 32'(i);
            refB[i]   = 32'(i);
        end
    endtask

    task automatic writeWord(input logic [4:0] a, input logic [31:0] d, input string tag);
        checkOutput({tag, ".ready"}, 32'(req_ready), 32'd1);
        applyStimulus(1'b1, 1'b1, a, d);
        nextCycle();
        refMem[a] = d;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput({tag, ".wr_done"}, 32'(wr_done), 32'd1);
    endtask

    // Issues a read now; during the burst it offers the "hold" request, and it
    // can assert rst during beat abortAt instead of finishing the burst.
    task automatic readBurst(input logic [4:0] addr, input logic holdValid, input logic holdWrite,
                             input logic [4:0] hAddr, input logic [31:0] hData,
                             input int abortAt, input string tag);
        logic [4:0] base;
        base = addr & 5'b11000;
        checkOutput({tag, ".ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, ".idle_valid"}, 32'(rd_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, addr, $urandom);
        nextCycle();
        if (holdValid) applyStimulus(1'b1, holdWrite, hAddr, hData);
        else           applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
        for (int c = 0; c < 2; c++) begin
            checkOutput({tag, ".wait_valid"}, 32'(rd_valid), 32'd0);
            checkOutput({tag, ".wait_busy"}, 32'(busy), 32'd1);
            checkOutput({tag, ".wait_ready"}, 32'(req_ready), 32'd0);
            checkOutput({tag, ".wait_wr_done"}, 32'(wr_done), 32'd0);
            nextCycle();
        end
        for (int k = 0; k < 8; k++) begin
            checkOutput({tag, ".beat_valid"}, 32'(rd_valid), 32'd1);
            checkOutput({tag, ".beat_data"}, rd_data, refMem[5'(32'(base) + k)]);
            checkOutput({tag, ".beat_last"}, 32'(rd_last), 32'(k == 7));
            checkOutput({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(k));
            checkOutput({tag, ".beat_ready"}, 32'(req_ready), 32'd0);
            if (k == abortAt) begin
                rst = 1'b1;
                applyStimulus(1'b1, 1'b1, 5'd3, 32'hBAD0_0003);
                nextCycle();
                rst = 1'b0;
                applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
                resetModel();
                checkOutput({tag, ".abort_valid"}, 32'(rd_valid), 32'd0);
                checkOutput({tag, ".abort_ready"}, 32'(req_ready), 32'd1);
                checkOutput({tag, ".abort_busy"}, 32'(busy), 32'd0);
                checkOutput({tag, ".abort_cnt"}, 32'(beat_cnt), 32'd0);
                checkOutput({tag, ".abort_data"}, rd_data, 32'd0);
                checkOutput({tag, ".abort_wr_done"}, 32'(wr_done), 32'd0);
                return;
            end
            nextCycle();
        end
        checkOutput({tag, ".done_valid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, ".done_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done_cnt"}, 32'(beat_cnt), 32'd8);
        checkOutput({tag, ".done_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, ".done_last"}, 32'(rd_last), 32'd0);
        checkOutput({tag, ".done_hold"}, rd_data, refMem[5'(base + 5'd7)]);
        if (!(holdValid && !holdWrite)) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
        nextCycle();
    endtask

    task automatic shortBurst(input logic [4:0] base, input string tag);
        for (int k = 0; k < 4; k++) begin
            checkOutput({tag, ".valid"}, 32'(b_rd_valid), 32'd1);
            checkOutput({tag, ".data"}, b_rd_data, refB[5'(32'(base) + k)]);
            checkOutput({tag, ".last"}, 32'(b_rd_last), 32'(k == 3));
            checkOutput({tag, ".ready"}, 32'(b_req_ready), 32'd0);
            applyShort(1'b1, 1'b1, base, 32'hFEED_0000 | 32'(k));
            nextCycle();
        end
        checkOutput({tag, ".done_valid"}, 32'(b_rd_valid), 32'd0);
        checkOutput({tag, ".done_cnt"}, 32'(b_beat_cnt), 32'd4);
        checkOutput({tag, ".done_busy"}, 32'(b_busy), 32'd0);
        applyShort(1'b0, 1'b0, 5'd0, 32'd0);
        nextCycle();
    endtask

    initial begin
        logic [4:0]  ra;
        logic [31:0] rd;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
        applyShort(1'b0, 1'b0, 5'd0, 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        resetModel();
        checkOutput("rst.ready", 32'(req_ready), 32'd1);
        checkOutput("rst.wr_done", 32'(wr_done), 32'd0);
        checkOutput("rst.rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst.rd_last", 32'(rd_last), 32'd0);
        checkOutput("rst.rd_data", rd_data, 32'd0);
        checkOutput("rst.beat_cnt", 32'(beat_cnt), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rstB.ready", 32'(b_req_ready), 32'd1);

        rd = $urandom;
        applyShort(1'b1, 1'b1, 5'd5, rd);
        nextCycle();
        refB[5] = rd;
        checkOutput("short.wr_done", 32'(b_wr_done), 32'd1);
        applyShort(1'b1, 1'b0, 5'd6, 32'd0);
        nextCycle();
        shortBurst(5'd4, "short.rd6");
        checkOutput("short.idle_ready", 32'(b_req_ready), 32'd1);
        applyShort(1'b1, 1'b0, 5'd4, 32'd0);
        nextCycle();
        shortBurst(5'd4, "short.rd4");

        readBurst(5'd0, 1'b0, 1'b0, 5'd0, 32'd0, -1, "rd0");
        readBurst(5'd13, 1'b0, 1'b0, 5'd0, 32'd0, -1, "rd13");
        writeWord(5'd9, 32'hDEAD_BEEF, "wr9");
        readBurst(5'd8, 1'b0, 1'b0, 5'd0, 32'd0, -1, "rd8");

        for (int it = 0; it < 6; it++) begin
            int nW;
            nW = int'($urandom_range(1, 3));
            for (int w = 0; w < nW; w++) begin
                writeWord(5'($urandom), $urandom, "rndwr");
            end
            ra = 5'($urandom);
            if (it % 2 == 1) begin
                readBurst(ra, 1'b1, 1'b1, ra, $urandom, -1, "rndrd_blk");
                readBurst(ra, 1'b0, 1'b0, 5'd0, 32'd0, -1, "rndrd_again");
            end else begin
                readBurst(ra, 1'b0, 1'b0, 5'd0, 32'd0, -1, "rndrd");
            end
        end

        readBurst(5'd0, 1'b1, 1'b0, 5'd24, 32'd0, -1, "b2b_first");
        readBurst(5'd24, 1'b0, 1'b0, 5'd0, 32'd0, -1, "b2b_second");

        readBurst(5'd16, 1'b0, 1'b0, 5'd0, 32'd0, 3, "abort");
        readBurst(5'd0, 1'b0, 1'b0, 5'd0, 32'd0, -1, "post_abort");

        $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end
endmodule
